// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with a start/busy/done handshake.
// Optional macro MUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   add_a, add_b, sum;
  logic [WIDTH:0]     carry;
  logic               cout;
  logic [2*WIDTH-1:0] p_next;

  // Ripple-carry adder stage: upper half of P plus the multiplicand when P[0] is set.
  always_comb begin
    add_a    = p[2*WIDTH-1:WIDTH];
    add_b    = p[0] ? a_reg : '0;
    sum      = '0;
    carry    = '0;
    carry[0] = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]     = add_a[i] ^ add_b[i] ^ carry[i];
      carry[i+1] = (add_a[i] & add_b[i]) | (carry[i] & (add_a[i] ^ add_b[i]));
    end
    cout   = carry[WIDTH];
    p_next = {cout, sum, p[WIDTH-1:1]};
  end

`ifdef MUL_EARLY_EXIT_EN
  localparam logic [WIDTH-1:0] ONES = '1;
  logic [WIDTH-1:0] rest;
  logic [CW-1:0]    shamt;

  // Multiplier bits not yet consumed sit in P[WIDTH-1-cnt:0].
  always_comb begin
    rest  = p[WIDTH-1:0] & (ONES >> cnt);
    shamt = CW'(WIDTH) - cnt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      p       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= mcand;
            p     <= {{WIDTH{1'b0}}, mplier};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
`ifdef MUL_EARLY_EXIT_EN
          if (rest == '0) begin
            product <= p >> shamt;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else
`endif
          begin
            p   <= p_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              product <= p_next;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised and directed bench for shift_add_multiplier; the reference is plain multiplication
// with latency derived from the multiplier value (honours MUL_EARLY_EXIT_EN).
module tb_shift_add_multiplier;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] last_prod = '0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] mp);
`ifdef MUL_EARLY_EXIT_EN
    int msb;
    if (mp == 0) return 1;
    msb = 0;
    for (int i = 0; i < W; i++) if (mp[i]) msb = i;
    return (msb + 2 < W) ? msb + 2 : W;
`else
    return W;
`endif
  endfunction

  // Called one #1 after the accepting edge; waits for done and checks everything along the way.
  task automatic wait_done(input int lat, input logic [2*W-1:0] want, input bit glitch);
    int  k;
    bit  got;
    k   = 0;
    got = 1'b0;
    check("busy_acc", {31'b0, busy}, 32'd1);
    while (!got && k < 3 * W) begin
      @(posedge clk); #1;
      k++;
      if (done) begin
        got = 1'b1;
      end else begin
        check("busy_calc", {31'b0, busy}, 32'd1);
        check("prod_hold", {16'b0, product}, {16'b0, last_prod});
      end
      if (glitch && k == 2 && !got) begin
        start  = 1'b1;
        mcand  = W'($urandom);
        mplier = W'($urandom);
      end else if (glitch) begin
        start = 1'b0;
      end
    end
    check("timeout", {31'b0, got}, 32'd1);
    check("latency", k, lat);
    check("product", {16'b0, product}, {16'b0, want});
    check("busy_done", {31'b0, busy}, 32'd0);
    last_prod = want;
  endtask

  task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input bit glitch);
    @(negedge clk);
    mcand  = mc;
    mplier = mp;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
    wait_done(exp_lat(mp), (2*W)'(mc) * (2*W)'(mp), glitch);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", {31'b0, done}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #3;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_prod", {16'b0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h0D, 8'h0B, 1'b0);
    run_op(8'h00, 8'hA5, 1'b0);

    // Back-to-back: start stays high, second operation accepted in the DONE cycle.
    @(negedge clk);
    mcand = 8'h12; mplier = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    mcand = 8'h80; mplier = 8'h02;
    wait_done(exp_lat(8'h34), 16'h03A8, 1'b0);
    @(posedge clk); #1;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_done", {31'b0, done}, 32'd0);
    start = 1'b0;
    mcand = W'($urandom); mplier = W'($urandom);
    // The accept edge was the one just passed; wait_done counts from there.
    wait_done(exp_lat(8'h02), 16'h0100, 1'b0);
    @(posedge clk); #1;
    check("b2b_pulse", {31'b0, done}, 32'd0);

    run_op(8'h3C, 8'hE7, 1'b1);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    mcand = 8'h5A; mplier = 8'hF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_prod", {16'b0, product}, 32'd0);
    last_prod = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h07, 8'h06, 1'b0);

    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h33, 8'h00, 1'b0);
    run_op(8'h01, 8'h80, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom_range(0, 255) >> $urandom_range(0, 7));
      run_op(a, b, bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
